// File: rtl/layer_scale_ctrl_fix_pkg.sv
// +----------------------------------------------------------------------+
// | fix_pkg: shared state encoding and width helpers for the layer scaler|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fix_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_FETCH = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int shamt_of(input int scale);
        return $clog2(scale);
    endfunction

    // Index ports keep at least one bit even for a single-element layer.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/layer_scale_ctrl_fix_if.sv
// +----------------------------------------------------------------------+
// | layer_scale_ctrl_fix_if: control, read-side and write-side bundle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface layer_scale_ctrl_fix_if #(
    parameter int WIDTH = 16,
    parameter int N     = 10
);
    import fix_pkg::*;

    localparam int AW = addr_w(N);
    localparam int CW = cnt_w(N);

    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    rd_en;
    logic [AW-1:0]           rd_addr;
    logic signed [WIDTH-1:0] rd_data;
    logic                    wr_en;
    logic                    wr_ready;
    logic [AW-1:0]           wr_addr;
    logic signed [WIDTH-1:0] wr_data;
    logic [CW-1:0]           min_cnt;

    modport master (
        input  start, rd_data, wr_ready,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, min_cnt
    );

    modport slave (
        output start, rd_data, wr_ready,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, min_cnt
    );

endinterface

`default_nettype wire

// File: rtl/layer_scale_ctrl_fix_scaler.sv
// +----------------------------------------------------------------------+
// | scaler_div_fix: signed divide by power of two, nonzero floored to |1||
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module scaler_div_fix
    import fix_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SCALE = 2
) (
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] dout,
    output logic                    forced_min
);

    localparam int SHAMT = shamt_of(SCALE);

    logic             w_neg;
    logic             w_zero;
    logic [WIDTH-1:0] w_abs;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_mag;

    assign w_neg  = din[WIDTH-1];
    assign w_zero = (din == '0);
    // Most-negative input negates to itself, which reads correctly as unsigned.
    assign w_abs  = w_neg ? $unsigned(-din) : $unsigned(din);

    generate
        if (SHAMT >= WIDTH) begin : g_shift_all
            assign w_shifted = '0;
        end else begin : g_shift
            assign w_shifted = w_abs >> SHAMT;
        end
    endgenerate

    assign forced_min = !w_zero && (w_shifted == '0);
    assign w_mag      = forced_min ? WIDTH'(1) : w_shifted;
    assign dout       = w_neg ? -$signed(w_mag) : $signed(w_mag);

endmodule

`default_nettype wire

// File: rtl/layer_scale_ctrl_fix.sv
// +----------------------------------------------------------------------+
// | layer_scale_ctrl_fix: reads N accumulators, scales, writes them out  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module layer_scale_ctrl_fix
    import fix_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SCALE = 2,
    parameter int N     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    layer_scale_ctrl_fix_if.master bus
);

    localparam int            AW   = addr_w(N);
    localparam int            CW   = cnt_w(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [AW-1:0]           r_idx;
    logic signed [WIDTH-1:0] r_wr_data;
    logic [CW-1:0]           r_min_cnt;

    logic signed [WIDTH-1:0] w_scaled;
    logic                    w_forced;
    logic                    w_accept;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_rd_en;
    logic                    w_wr_en;

    scaler_div_fix #(
        .WIDTH (WIDTH),
        .SCALE (SCALE)
    ) u_scaler (
        .din        (bus.rd_data),
        .dout       (w_scaled),
        .forced_min (w_forced)
    );

    assign w_accept = (r_state == ST_WR) && bus.wr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = ST_RD;
                end
            end
            ST_RD: begin
                w_rd_en = 1'b1;
                w_next  = ST_FETCH;
            end
            ST_FETCH: begin
                w_next = ST_WR;
            end
            ST_WR: begin
                w_wr_en = 1'b1;
                if (w_accept) begin
                    w_next = (r_idx == LAST) ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    // Index advances only on an accepted write, so wr_addr always names the element in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_wr_data <= '0;
            r_min_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && bus.start) begin
                r_idx     <= '0;
                r_min_cnt <= '0;
            end
            if (r_state == ST_FETCH) begin
                r_wr_data <= w_scaled;
                if (w_forced) begin
                    r_min_cnt <= r_min_cnt + CW'(1);
                end
            end
            if (w_accept && (r_idx != LAST)) begin
                r_idx <= r_idx + AW'(1);
            end
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.rd_en   = w_rd_en;
    assign bus.rd_addr = r_idx;
    assign bus.wr_en   = w_wr_en;
    assign bus.wr_addr = r_idx;
    assign bus.wr_data = r_wr_data;
    assign bus.min_cnt = r_min_cnt;

endmodule

`default_nettype wire

// File: tb/tb_layer_scale_ctrl_fix.sv
// +----------------------------------------------------------------------+
// | tb_layer_scale_ctrl_fix: vector table, corner sequences, random passes|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_layer_scale_ctrl_fix;
    import fix_pkg::*;

    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst2_n;
    int   checks = 0;
    int   errors = 0;

    layer_scale_ctrl_fix_if #(.WIDTH(W), .N(N)) bus  ();
    layer_scale_ctrl_fix_if #(.WIDTH(W), .N(N)) bus2 ();

    layer_scale_ctrl_fix #(.WIDTH(W), .SCALE(4), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    layer_scale_ctrl_fix #(.WIDTH(W), .SCALE(65536), .N(N)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2.master)
    );

    // Accumulator buffers: data presented for the cycle after the read strobe.
    logic signed [15:0] mem  [N];
    logic signed [15:0] mem2 [N];
    always @(negedge clk) begin
        if (bus.rd_en)  bus.rd_data  = mem[bus.rd_addr];
        if (bus2.rd_en) bus2.rd_data = mem2[bus2.rd_addr];
    end

    typedef struct packed {
        logic [1:0]         a;
        logic signed [15:0] d;
    } wr_t;
    wr_t wq[$];
    int  exp_d [N];

    typedef struct packed {
        logic [N-1:0][15:0] d;
        logic [N-1:0][15:0] e;
        int mc;
        int slo;
        int shi;
        int pa;
        int pb;
        int lat;
    } vec_t;
    vec_t vt [4];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0][15:0] pk(input int a, input int b, input int c, input int d);
        logic [N-1:0][15:0] r;
        r[0] = a[15:0];
        r[1] = b[15:0];
        r[2] = c[15:0];
        r[3] = d[15:0];
        return r;
    endfunction

    // Reference: divide magnitude by 2**shamt, floor nonzero results to 1, keep sign.
    function automatic int ref_scale(input int x, input int shamt, input int width, output bit forced);
        int m;
        forced = 1'b0;
        if (x == 0) return 0;
        m = (x < 0 ? -x : x) / (1 << shamt);
        if (m == 0) begin
            m      = 1;
            forced = 1'b1;
        end
        if (shamt >= width - 1) m = 1;
        return (x < 0) ? -m : m;
    endfunction

    task automatic run_pass(input int slo, input int shi, input bit rnd, input int pa,
                            input int pb, input int rst_at, output int lat);
        logic               hold_v;
        logic [1:0]         hold_a;
        logic signed [15:0] hold_d;
        wr_t                w;
        hold_v = 1'b0;
        hold_a = '0;
        hold_d = '0;
        lat    = -1;
        wq.delete();
        bus.start    = 1'b1;
        bus.wr_ready = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            bus.start    = (c == pa) || (c == pb);
            rst_n        = (c != rst_at);
            bus.wr_ready = rnd ? ($urandom_range(0, 3) != 0) : !(c >= slo && c <= shi);
            @(negedge clk);
            if (bus.wr_en) begin
                if (hold_v) begin
                    chk("stall_addr_stable", bus.wr_addr, hold_a);
                    chk("stall_data_stable", bus.wr_data, hold_d);
                end
                if (bus.wr_ready) begin
                    w.a = bus.wr_addr;
                    w.d = bus.wr_data;
                    wq.push_back(w);
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    hold_a = bus.wr_addr;
                    hold_d = bus.wr_data;
                end
            end else begin
                hold_v = 1'b0;
            end
            if (rst_at > 0 && c == rst_at + 1) begin
                chk("reset_mid_outputs_zero", {bus.busy, bus.done, bus.rd_en, bus.wr_en,
                    bus.rd_addr, bus.wr_addr, bus.wr_data, bus.min_cnt}, 0);
                chk("reset_mid_state_idle", dut.r_state, ST_IDLE);
                lat = -2;
                break;
            end
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        @(posedge clk); #1;
        bus.start    = 1'b0;
        rst_n        = 1'b1;
        bus.wr_ready = 1'b1;
        if (lat == -1) chk("pass_timeout", 0, 1);
    endtask

    task automatic check_writes(input int mc);
        chk("write_count", wq.size(), N);
        for (int i = 0; i < wq.size() && i < N; i++) begin
            chk("write_addr", wq[i].a, i);
            chk("write_data", $signed(wq[i].d), exp_d[i]);
        end
        chk("min_cnt", bus.min_cnt, mc);
    endtask

    initial begin
        int lat;
        int mc;
        int c2;
        bit f;
        wr_t w;
        wr_t wq2[$];

        vt[0] = '{d: pk(0, 100, -100, 3), e: pk(0, 25, -25, 1), mc: 1,
                  slo: 0, shi: 0, pa: 0, pb: 0, lat: 13};
        vt[1] = '{d: pk(-3, -32767, 32767, -4), e: pk(-1, -8191, 8191, -1), mc: 1,
                  slo: 0, shi: 0, pa: 0, pb: 0, lat: 13};
        vt[2] = '{d: pk(8, -9, 1, -1), e: pk(2, -2, 1, -1), mc: 2,
                  slo: 6, shi: 10, pa: 0, pb: 0, lat: 18};
        vt[3] = '{d: pk(400, -400, 2, 0), e: pk(100, -100, 1, 0), mc: 1,
                  slo: 0, shi: 0, pa: 3, pb: 13, lat: 13};

        rst_n         = 1'b0;
        rst2_n        = 1'b0;
        bus.start     = 1'b0;
        bus.wr_ready  = 1'b1;
        bus2.start    = 1'b0;
        bus2.wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", {bus.busy, bus.done, bus.rd_en, bus.wr_en,
            bus.rd_addr, bus.wr_addr, bus.wr_data, bus.min_cnt}, 0);
        chk("reset_state_idle", dut.r_state, ST_IDLE);
        chk("reset2_outputs_zero", {bus2.busy, bus2.done, bus2.rd_en, bus2.wr_en,
            bus2.wr_data, bus2.min_cnt}, 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < N; i++) begin
                mem[i]   = vt[v].d[i];
                exp_d[i] = $signed(vt[v].e[i]);
            end
            run_pass(vt[v].slo, vt[v].shi, 1'b0, vt[v].pa, vt[v].pb, 0, lat);
            chk("latency", lat, vt[v].lat);
            check_writes(vt[v].mc);
            @(negedge clk);
            chk("idle_after_done", bus.busy, 0);
            repeat (3) @(negedge clk);
            chk("no_extra_pass", wq.size() + int'(bus.busy), N);
            chk("min_cnt_held", bus.min_cnt, vt[v].mc);
            @(posedge clk); #1;
        end

        // Reset during the write of element 2, with that write held off.
        mem[0] = 16'sd10; mem[1] = 16'sd20; mem[2] = 16'sd30; mem[3] = 16'sd40;
        run_pass(9, 9, 1'b0, 0, 0, 9, lat);
        chk("reset_abort_writes", wq.size(), 2);
        repeat (3) @(negedge clk);
        chk("reset_abort_quiet", {bus.busy, bus.wr_en}, 0);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) exp_d[i] = ref_scale(mem[i], 2, W, f);
        run_pass(0, 0, 1'b0, 0, 0, 0, lat);
        chk("post_reset_latency", lat, 13);
        check_writes(0);

        // Randomized passes with random back-pressure against the reference model.
        for (int p = 0; p < 8; p++) begin
            mc = 0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0) mem[i] = 16'(int'($urandom_range(0, 8)) - 4);
                else                           mem[i] = 16'($urandom);
                exp_d[i] = ref_scale(mem[i], 2, W, f);
                mc += int'(f);
            end
            run_pass(0, 0, 1'b1, 0, 0, 0, lat);
            chk("rand_latency_min", lat >= 3 * N + 1, 1);
            check_writes(mc);
        end

        // Divisor wider than the data word: every nonzero value becomes +/-1.
        mem2[0] = 16'sd5; mem2[1] = -16'sd7; mem2[2] = 16'sd0; mem2[3] = 16'sd1;
        bus2.start = 1'b1;
        lat = -1;
        for (c2 = 1; c2 <= 100; c2++) begin
            @(posedge clk); #1;
            bus2.start = 1'b0;
            @(negedge clk);
            if (bus2.wr_en && bus2.wr_ready) begin
                w.a = bus2.wr_addr;
                w.d = bus2.wr_data;
                wq2.push_back(w);
            end
            if (bus2.done) begin
                lat = c2;
                break;
            end
        end
        chk("wide_latency", lat, 13);
        chk("wide_write_count", wq2.size(), N);
        exp_d[0] = 1; exp_d[1] = -1; exp_d[2] = 0; exp_d[3] = 1;
        for (int i = 0; i < wq2.size() && i < N; i++) begin
            chk("wide_write_addr", wq2[i].a, i);
            chk("wide_write_data", $signed(wq2[i].d), exp_d[i]);
        end
        chk("wide_min_cnt", bus2.min_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/layer_scale_ctrl_fix.md
LAYER_SCALE_CTRL_FIX -- requirements
Module: layer_scale_ctrl_fix

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the signed fixed-point data width.
REQ-002 SHALL have parameter SCALE, default 2, a power-of-two divisor; SHAMT = clog2(SCALE).
REQ-003 SHALL have parameter N, default 10, the number of neuron values per layer pass.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port start, input, 1, a pass request, sampled only in IDLE.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse at pass completion.
REQ-009 SHALL have port rd_en, output, 1, the accumulator-buffer read strobe.
REQ-010 SHALL have port rd_addr, output, clog2(N), the accumulator read index.
REQ-011 SHALL have port rd_data, input, WIDTH signed, valid exactly one cycle after rd_en.
REQ-012 SHALL have port wr_en, output, 1, the output-buffer write valid.
REQ-013 SHALL have port wr_ready, input, 1, downstream accept; a write completes on wr_en && wr_ready.
REQ-014 SHALL have port wr_addr, output, clog2(N), the write index.
REQ-015 SHALL have port wr_data, output, WIDTH signed, the scaled value.
REQ-016 SHALL have port min_cnt, output, clog2(N+1), the count of nonzero inputs forced to magnitude 1 in the current or last pass.

Function
REQ-017 SHALL implement FSM states IDLE, RD, FETCH, WR, DONE.
- IDLE->RD on start.
- RD->FETCH unconditionally.
- FETCH->WR unconditionally.
- WR->RD on accept when idx<N-1; WR->DONE on accept when idx==N-1; WR stays in WR otherwise.
- DONE->IDLE unconditionally.
REQ-018 SHALL, on the IDLE->RD transition, clear idx and min_cnt to 0.
REQ-019 SHALL assert rd_en=1 with rd_addr=idx in RD only; in every other state rd_en=0.
REQ-020 SHALL, in FETCH, register the scaled rd_data into wr_data and assert wr_en from the following cycle (WR).
REQ-021 SHALL compute the scaled value as follows:
- 0 maps to 0.
- Otherwise: magnitude = |x| >> SHAMT; if the result is 0, magnitude = 1; the input sign is reapplied.
- If SHAMT >= WIDTH-1, every nonzero input maps to magnitude 1 with its sign.
REQ-022 SHALL increment min_cnt in FETCH when rd_data != 0 and (|rd_data| >> SHAMT) == 0.
REQ-023 SHALL hold wr_en, wr_addr and wr_data stable in WR while wr_ready=0.
REQ-024 SHALL set wr_addr equal to the idx that produced wr_data.
REQ-025 SHALL drop wr_en in the cycle after an accept.
REQ-026 SHALL assert done=1 only in DONE; busy=0 in the DONE->IDLE following cycle.
REQ-027 SHALL, with wr_ready tied high, have start-to-done latency exactly 3N+1 cycles (done high in cycle 3N+1 after the start-sampling cycle).
REQ-028 SHALL ignore start while busy=1, including in DONE.
REQ-029 SHALL hold min_cnt after DONE until the next accepted start.

Reset
REQ-030 SHALL, on rst_n=0 at a clk edge, force state=IDLE, idx=0, and busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data, min_cnt all =0.
REQ-031 SHALL abort an in-flight pass on reset mid-operation with no further writes; a subsequent start SHALL begin a fresh pass from index 0.

Structure
REQ-032 SHALL place the FSM state enum and the SHAMT/address-width localparam helpers in shared package fix_pkg.
REQ-033 SHALL contain exactly one sub-module: a combinational scaler_div_fix instance (WIDTH, SCALE) on rd_data, with its output registered per REQ-020.

Verification (WIDTH=16, SCALE=4, N=4 unless stated)
REQ-034 SHALL cover: rd_data {0,100,-100,3}, wr_ready=1 -> writes {0,25,-25,1} at addr 0..3, min_cnt=1, done in cycle 13.
REQ-035 SHALL cover: rd_data {-3,-32767,32767,-4} -> writes {-1,-8191,8191,-1}, min_cnt=1.
REQ-036 SHALL cover: wr_ready=0 for 5 cycles at element 1 -> wr_data/wr_addr stable throughout, done delayed to cycle 18.
REQ-037 SHALL cover: start pulsed in cycles 3 and 13 of a pass -> a single pass only, exactly 4 writes.
REQ-038 SHALL cover: rst_n=0 during WR of element 2 -> next cycle all outputs 0 and state IDLE; a new start completes a full 4-write pass.
REQ-039 SHALL cover: SCALE=65536, WIDTH=16, rd_data {5,-7,0,1} -> writes {1,-1,0,1}, min_cnt=3.
